// File: rtl/sim_finish_monitor.sv
// End-of-simulation monitor: per-hart ecall drain/sample FSMs feeding a global pass/fail/timeout FSM.
// Optional per-hart retire stall watchdog enabled by defining SIM_FINISH_STALL_WDT_EN.
module sim_finish_monitor #(
    parameter int unsigned NUM_HARTS    = 1,
    parameter int unsigned TO_BIT       = 18,
    parameter int unsigned DRAIN_CYCLES = 255,
    parameter logic [31:0] PASS_CODE    = 32'd1,
    parameter int unsigned STALL_BIT    = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_HARTS-1:0]    ecall_i,
    input  logic [32*NUM_HARTS-1:0] gp_i,
    input  logic [NUM_HARTS-1:0]    retire_i,
    output logic [NUM_HARTS-1:0]    hart_done_o,
    output logic [NUM_HARTS-1:0]    hart_pass_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic                    fail_o,
    output logic                    timeout_o,
    output logic [31:0]             fail_code_o,
    output logic [TO_BIT-1:0]       cycle_cnt_o
);

    typedef enum logic [1:0] {StRun, StDrain, StDone} hart_state_e;
    typedef enum logic [1:0] {GlbRun, GlbPass, GlbFail, GlbTimeout} glb_state_e;

    localparam logic [15:0] DrainLast = 16'(DRAIN_CYCLES);

    hart_state_e hart_q [NUM_HARTS];
    hart_state_e hart_d [NUM_HARTS];
    logic [15:0] drain_q [NUM_HARTS];
    logic [15:0] drain_d [NUM_HARTS];
    logic [31:0] gp_q [NUM_HARTS];
    logic [31:0] gp_d [NUM_HARTS];
    logic [NUM_HARTS-1:0] pass_q, pass_d;

    glb_state_e glb_q, glb_d;
    logic [TO_BIT-1:0] cnt_q, cnt_d;
    logic stall_hit;

`ifdef SIM_FINISH_STALL_WDT_EN
    logic [STALL_BIT-1:0] stall_q [NUM_HARTS];
    logic [STALL_BIT-1:0] stall_d [NUM_HARTS];

    always_comb begin
        stall_hit = 1'b0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            stall_d[h] = stall_q[h];
            if (glb_q == GlbRun && hart_q[h] == StRun) begin
                if (retire_i[h]) begin
                    stall_d[h] = '0;
                end else if (!(&stall_q[h])) begin
                    stall_d[h] = stall_q[h] + 1'b1;
                end
                if (&stall_q[h]) begin
                    stall_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                stall_q[h] <= '0;
            end
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    logic                 unused_retire;
    logic [STALL_BIT-1:0] unused_stall_w;
    assign unused_retire  = ^retire_i;
    assign unused_stall_w = '0;
    assign stall_hit      = 1'b0;
`endif

    // Hart FSMs only advance while the global FSM is still running.
    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            hart_d[h]  = hart_q[h];
            drain_d[h] = drain_q[h];
            gp_d[h]    = gp_q[h];
            pass_d[h]  = pass_q[h];
            if (glb_q == GlbRun) begin
                case (hart_q[h])
                    StRun: begin
                        if (ecall_i[h]) begin
                            hart_d[h]  = StDrain;
                            drain_d[h] = 16'd1;
                        end
                    end
                    StDrain: begin
                        if (drain_q[h] == DrainLast) begin
                            hart_d[h] = StDone;
                            gp_d[h]   = gp_i[32*h +: 32];
                            pass_d[h] = (gp_i[32*h +: 32] == PASS_CODE);
                        end else begin
                            drain_d[h] = drain_q[h] + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            hart_done_o[h] = (hart_q[h] == StDone);
        end
    end
    assign hart_pass_o = pass_q;

    always_comb begin
        glb_d = glb_q;
        cnt_d = cnt_q;
        if (glb_q == GlbRun) begin
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + 1'b1;
            end
            // Completion takes priority over any timeout source in the same cycle.
            if (&hart_done_o) begin
                glb_d = (&pass_q) ? GlbPass : GlbFail;
            end else if ((&cnt_q) || stall_hit) begin
                glb_d = GlbTimeout;
            end
        end
    end

    always_comb begin
        fail_code_o = 32'd0;
        if (glb_q == GlbFail) begin
            for (int h = NUM_HARTS - 1; h >= 0; h--) begin
                if (hart_done_o[h] && !pass_q[h]) begin
                    fail_code_o = gp_q[h];
                end
            end
        end
    end

    assign done_o      = (glb_q != GlbRun);
    assign pass_o      = (glb_q == GlbPass);
    assign fail_o      = (glb_q == GlbFail);
    assign timeout_o   = (glb_q == GlbTimeout);
    assign cycle_cnt_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                hart_q[h]  <= StRun;
                drain_q[h] <= '0;
                gp_q[h]    <= '0;
            end
            pass_q <= '0;
            glb_q  <= GlbRun;
            cnt_q  <= '0;
        end else begin
            hart_q  <= hart_d;
            drain_q <= drain_d;
            gp_q    <= gp_d;
            pass_q  <= pass_d;
            glb_q   <= glb_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
